// File: rtl/mill_modif_mod.sv
// mill_modif_mod: modified Miller encoder (ISO 14443A PCD->PICC), frame -> pause envelope
// Ports: clk, in_PoR (async active-high reset), in_enable (low aborts), in_start (1-cycle request),
//        in_data[M-1:0] (bit 0 sent first), in_len (clamped to M), out_data (1 = carrier, 0 = pause),
//        out_busy (frame in progress), out_done (1-cycle completion pulse).
// Option: define MILL_PARITY_EN to insert an odd-parity bit after every full payload byte.
module mill_modif_mod #(
  parameter int M          = 256,
  parameter int LEN_W      = 9,
  parameter int ETU_CLKS   = 32,
  parameter int PAUSE_CLKS = 8
) (
  input  logic             clk,
  input  logic             in_PoR,
  input  logic             in_enable,
  input  logic             in_start,
  input  logic [M-1:0]     in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             out_data,
  output logic             out_busy,
  output logic             out_done
);
  localparam int CW = $clog2(ETU_CLKS);
  localparam logic [CW-1:0] C_LAST  = CW'(ETU_CLKS - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(ETU_CLKS / 2);
  localparam logic [CW-1:0] C_PAUSE = CW'(PAUSE_CLKS);
  localparam logic [CW-1:0] C_XEND  = CW'(ETU_CLKS / 2 + PAUSE_CLKS);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(M);
  typedef enum logic [2:0] {IDLE, SOF, DATA, EOF0, EOFY} state_t;
  typedef enum logic [1:0] {SYM_Y, SYM_X, SYM_Z} sym_t;
  state_t st_q, st_d;
  sym_t sym_q, sym_d;
  logic [CW-1:0] c_q, c_d;
  logic [LEN_W-1:0] bits_q, bits_d, rem;
  logic [M-1:0] sh_q, sh_d;
  logic cur_q, cur_d, nxt;
  logic data_q, data_d, busy_q, busy_d, done_q, done_d;
  logic start_ok, last, data_edge, is_par, ins_par, par_bit;
  function automatic sym_t code(input logic b, input logic prev_one);
    return b ? SYM_X : prev_one ? SYM_Y : SYM_Z;
  endfunction
  assign start_ok  = st_q == IDLE && in_enable && in_start;
  assign last      = c_q == C_LAST;
  assign data_edge = st_q == DATA && in_enable && last;
`ifdef MILL_PARITY_EN
  logic [2:0] pcnt_q;
  logic par_q, is_par_q;
  // par_q holds the XOR of the byte's bits sent so far; the parity symbol follows bit 7
  assign is_par  = is_par_q;
  assign ins_par = !is_par_q && pcnt_q == 3'd7;
  assign par_bit = ~(par_q ^ cur_q);
  always_ff @(posedge clk or posedge in_PoR)
    if (in_PoR) begin
      pcnt_q   <= '0;
      par_q    <= 1'b0;
      is_par_q <= 1'b0;
    end else if (start_ok) begin
      pcnt_q   <= '0;
      par_q    <= 1'b0;
      is_par_q <= 1'b0;
    end else if (data_edge) begin
      is_par_q <= is_par_q ? 1'b0 : ins_par;
      pcnt_q   <= is_par_q ? pcnt_q : pcnt_q + 3'd1;
      par_q    <= is_par_q ? par_q : ins_par ? 1'b0 : par_q ^ cur_q;
    end
`else
  assign is_par  = 1'b0;
  assign ins_par = 1'b0;
  assign par_bit = 1'b0;
`endif
  // Registers describe the symbol/cycle being output; out_data is computed from the next values
  always_comb begin
    st_d   = st_q;
    sym_d  = sym_q;
    c_d    = c_q + 1'b1;
    bits_d = bits_q;
    sh_d   = sh_q;
    cur_d  = cur_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem    = is_par ? bits_q : bits_q - 1'b1;
    nxt    = is_par ? sh_q[0] : ins_par ? par_bit : sh_q[1];
    if (st_q == IDLE) begin
      c_d = '0;
      if (start_ok) begin
        st_d   = SOF;
        sym_d  = SYM_Z;
        sh_d   = in_data;
        bits_d = in_len > L_MAX ? L_MAX : in_len;
        cur_d  = 1'b0;
        busy_d = 1'b1;
      end
    end else if (!in_enable) begin
      st_d   = IDLE;
      c_d    = '0;
      busy_d = 1'b0;
    end else if (last) begin
      c_d = '0;
      case (st_q)
        SOF: begin
          st_d  = bits_q == '0 ? EOF0 : DATA;
          cur_d = bits_q == '0 ? 1'b0 : sh_q[0];
          sym_d = code(cur_d, 1'b0);
        end
        DATA: begin
          bits_d = is_par ? bits_q : bits_q - 1'b1;
          sh_d   = is_par ? sh_q : sh_q >> 1;
          st_d   = rem == '0 && !ins_par ? EOF0 : DATA;
          cur_d  = rem == '0 && !ins_par ? 1'b0 : nxt;
          sym_d  = code(cur_d, cur_q);
        end
        EOF0: begin
          st_d  = EOFY;
          sym_d = SYM_Y;
        end
        EOFY: begin
          st_d   = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        default: st_d = IDLE;
      endcase
    end
    data_d = st_d == IDLE ||
             !(sym_d == SYM_Z ? c_d < C_PAUSE :
               sym_d == SYM_X ? (c_d >= C_HALF && c_d < C_XEND) : 1'b0);
  end
  always_ff @(posedge clk or posedge in_PoR)
    if (in_PoR) begin
      st_q   <= IDLE;
      sym_q  <= SYM_Y;
      c_q    <= '0;
      bits_q <= '0;
      sh_q   <= '0;
      cur_q  <= 1'b0;
      data_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sym_q  <= sym_d;
      c_q    <= c_d;
      bits_q <= bits_d;
      sh_q   <= sh_d;
      cur_q  <= cur_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign out_data = data_q;
  assign out_busy = busy_q;
  assign out_done = done_q;
endmodule
